// File: rtl/npc_pkg.sv
// npc_pkg: definitions shared by the NPC core blocks.
//   ifu_state_e      - fetch unit FSM states
//   AXI_RESP_OKAY    - AXI read response value that means success
//   DEFAULT_RESET_PC - default reset program counter
package npc_pkg;

    typedef enum logic [1:0] {
        S_ADDR = 2'd0,
        S_DATA = 2'd1,
        S_OUT  = 2'd2,
        S_WAIT = 2'd3
    } ifu_state_e;

    localparam logic [1:0]  AXI_RESP_OKAY    = 2'b00;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ifu_perf_cnt.sv
// ifu_perf_cnt: performance counters for the fetch unit.
// This module is built only when IFU_PERF_EN is defined.
// Ports:
//   clk, rst       - clock and synchronous active-high reset
//   fetch_fire     - an instruction is handed to decode this cycle
//   stall          - the fetch unit is waiting on the memory this cycle
//   perf_fetch_cnt - count of instructions handed to decode (wraps at 2^64)
//   perf_stall_cnt - count of cycles spent waiting on memory (wraps at 2^64)
module ifu_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_fire,
    input  logic        stall,
    output logic [63:0] perf_fetch_cnt,
    output logic [63:0] perf_stall_cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (fetch_fire) perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
            if (stall)      perf_stall_cnt <= perf_stall_cnt + 64'd1;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit for the multicycle NPC core.
// The unit holds the PC and issues one AXI-lite read per instruction. It passes
// the fetched word to decode, then waits for writeback to supply the next PC.
// Only one fetch is in flight at a time.
//
// Optional feature macro: IFU_PERF_EN. When it is defined, the perf_fetch_cnt and
// perf_stall_cnt ports and their counters exist.
//
// Handshake rule: a transfer happens on a rising edge where valid and ready are
// both high. A valid signal and its payload stay stable from assertion until that
// transfer.
//
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   araddr/arvalid/arready         - AXI-lite read-address channel (araddr == pc)
//   rdata/rvalid/rresp/rready      - AXI-lite read-data channel
//   inst/inst_pc/inst_fault/inst_valid/inst_ready - decode handshake
//   npc/npc_valid       - next PC from writeback; it is used only while waiting
//   state_dbg           - current FSM state, for debug
//   perf_fetch_cnt/perf_stall_cnt - 64-bit counters (only with IFU_PERF_EN)
module ifu_fetch
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    input  logic [1:0]  rresp,
    output logic        rready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic [31:0] npc,
    input  logic        npc_valid,
    output logic [1:0]  state_dbg
`ifdef IFU_PERF_EN
    ,
    output logic [63:0] perf_fetch_cnt,
    output logic [63:0] perf_stall_cnt
`endif
);

    ifu_state_e  state;
    logic [31:0] pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_ADDR;
            pc         <= RESET_PC;
            inst       <= '0;
            inst_pc    <= '0;
            inst_fault <= 1'b0;
        end else begin
            case (state)
                S_ADDR: begin
                    if (arready) state <= S_DATA;
                end
                S_DATA: begin
                    if (rvalid) begin
                        inst       <= rdata;
                        inst_fault <= (rresp != AXI_RESP_OKAY);
                        inst_pc    <= pc;
                        state      <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (inst_ready) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (npc_valid) begin
                        pc <= npc;
                        if (npc[1:0] == 2'b00) begin
                            state <= S_ADDR;
                        end else begin
                            // A misaligned target never reaches the bus. The
                            // fault is reported straight to decode.
                            inst       <= '0;
                            inst_fault <= 1'b1;
                            inst_pc    <= npc;
                            state      <= S_OUT;
                        end
                    end
                end
                default: state <= S_ADDR;
            endcase
        end
    end

    // arvalid is gated by rst so that it reads 0 during reset. The state register
    // already holds S_ADDR in that case, so the first cycle after reset issues
    // the request at once.
    assign arvalid    = (state == S_ADDR) && !rst;
    assign araddr     = pc;
    assign rready     = (state == S_DATA);
    assign inst_valid = (state == S_OUT);
    assign state_dbg  = state;

`ifdef IFU_PERF_EN
    ifu_perf_cnt u_perf (
        .clk            (clk),
        .rst            (rst),
        .fetch_fire     (inst_valid && inst_ready),
        .stall          ((state == S_ADDR) || (state == S_DATA)),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );
`endif

endmodule
